// File: rtl/stopwatch_controller_pkg.sv
// Shared state encodings and sizing helper for the stopwatch controller and its datapath.
package stopwatch_controller_pkg;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StPause = 2'd2;
    localparam logic [1:0] StLap   = 2'd3;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stopwatch_controller_debounce_filter.sv
// Debounces one raw push-button and emits a one-cycle press event on each accepted rising edge.
module debounce_filter
    import stopwatch_controller_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = 250_000
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Raw,
    output logic o_Level,
    output logic o_Press
);

    localparam int unsigned CntW = cnt_width(DEBOUNCE_LIMIT);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_LIMIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            level_prev_q;
    logic            press_q;

    // Any sample agreeing with the stable level restarts the qualification window.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (i_Raw != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = i_Raw;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            press_q      <= level_q & ~level_prev_q;
        end
    end

    assign o_Level = level_q;
    assign o_Press = press_q;

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch sequencer: debounced START/STOP and LAP/CLEAR buttons drive a start/pause/lap/clear
// FSM and a half-second tick generator feeding the two-digit counter.
module stopwatch_controller
    import stopwatch_controller_pkg::*;
#(
    parameter int unsigned HALF_SECOND    = 12_500_000,
    parameter int unsigned DEBOUNCE_LIMIT = 250_000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Switch_1,
    input  logic       i_Switch_2,
    output logic       o_Tick,
    output logic       o_Clear,
    output logic       o_Hold,
    output logic [1:0] o_State
);

    localparam int unsigned TickW = cnt_width(HALF_SECOND);
    localparam logic [TickW-1:0] TickMax = TickW'(HALF_SECOND - 1);

    logic start_level, start_press;
    logic lap_level, lap_press;
    logic unused_levels;

    logic [1:0]       state_q, state_d;
    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic             tick_q, tick_d;
    logic             counting;

    debounce_filter #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_start_db (
        .i_Clk  (i_Clk),
        .i_Rst_n(i_Rst_n),
        .i_Raw  (i_Switch_1),
        .o_Level(start_level),
        .o_Press(start_press)
    );

    debounce_filter #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_lap_db (
        .i_Clk  (i_Clk),
        .i_Rst_n(i_Rst_n),
        .i_Raw  (i_Switch_2),
        .o_Level(lap_level),
        .o_Press(lap_press)
    );

    assign unused_levels = start_level ^ lap_level;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Simultaneous presses act as a clear and override every other transition.
    always_comb begin
        state_d = state_q;
        if (start_press && lap_press) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_press) state_d = StRun;
                end
                StRun: begin
                    if (start_press)    state_d = StPause;
                    else if (lap_press) state_d = StLap;
                end
                StPause: begin
                    if (start_press)    state_d = StRun;
                    else if (lap_press) state_d = StIdle;
                end
                StLap: begin
                    if (lap_press)        state_d = StRun;
                    else if (start_press) state_d = StPause;
                end
            endcase
        end
    end

    always_comb begin
        o_Clear = (state_q == StIdle);
        o_Hold  = (state_q == StLap);
        o_State = state_q;
        o_Tick  = tick_q;
    end

    // Pause keeps the phase so a resumed run still totals HALF_SECOND cycles per tick.
    assign counting = (state_q == StRun) || (state_q == StLap);

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        tick_d     = 1'b0;
        if (state_q == StIdle) begin
            tick_cnt_d = '0;
        end else if (counting) begin
            if (tick_cnt_q == TickMax) begin
                tick_cnt_d = '0;
                tick_d     = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_d;
        end
    end

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed bench for stopwatch_controller with HALF_SECOND=50 and DEBOUNCE_LIMIT=4.
module tb_stopwatch_controller;

    localparam int unsigned HalfSecond    = 50;
    localparam int unsigned DebounceLimit = 4;

    logic       clk;
    logic       rst_n;
    logic       sw1;
    logic       sw2;
    logic       o_tick;
    logic       o_clear;
    logic       o_hold;
    logic [1:0] o_state;

    int n_checks  = 0;
    int n_pass    = 0;
    int cyc       = 0;
    int tick_cnt  = 0;
    int first_tick = -1;
    int wide_cnt  = 0;
    logic prev_tick = 1'b0;
    int run_cyc, t_tick, r_cyc;

    stopwatch_controller #(
        .HALF_SECOND   (HalfSecond),
        .DEBOUNCE_LIMIT(DebounceLimit)
    ) dut (
        .i_Clk     (clk),
        .i_Rst_n   (rst_n),
        .i_Switch_1(sw1),
        .i_Switch_2(sw2),
        .o_Tick    (o_tick),
        .o_Clear   (o_clear),
        .o_Hold    (o_hold),
        .o_State   (o_state)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clock edges, sampling 1 ns after each edge and tallying tick pulses.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (o_tick) begin
                tick_cnt++;
                if (first_tick < 0) first_tick = cyc;
                if (prev_tick) wide_cnt++;
            end
            prev_tick = o_tick;
        end
    endtask

    task automatic clear_ticks();
        tick_cnt   = 0;
        first_tick = -1;
        wide_cnt   = 0;
    endtask

    initial begin
        #(40 * 20000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        sw1   = 1'b0;
        sw2   = 1'b0;
        step(3);
        check_eq("rst_state", o_state, 0);
        check_eq("rst_clear", o_clear, 1);
        check_eq("rst_tick", o_tick, 0);
        check_eq("rst_hold", o_hold, 0);

        rst_n = 1'b1;
        clear_ticks();
        step(200);
        check_eq("idle_no_ticks", tick_cnt, 0);
        check_eq("idle_state", o_state, 0);

        // Glitch shorter than the debounce window.
        sw1 = 1'b1;
        step(3);
        sw1 = 1'b0;
        step(10);
        check_eq("glitch_state", o_state, 0);

        // Valid press: state changes exactly DEBOUNCE_LIMIT+2 edges after the rise.
        sw1 = 1'b1;
        step(5);
        check_eq("start_edge5", o_state, 0);
        step(1);
        check_eq("start_edge6", o_state, 1);
        check_eq("run_clear", o_clear, 0);
        run_cyc = cyc;
        clear_ticks();
        step(4);
        sw1 = 1'b0;
        step(246);
        check_eq("run_first_tick", first_tick - run_cyc, 50);
        check_eq("run_tick_count", tick_cnt, 5);
        check_eq("run_tick_width", wide_cnt, 0);

        // Pause 20 edges after a tick, then resume.
        t_tick = cyc;
        step(14);
        sw1 = 1'b1;
        step(6);
        check_eq("pause_state", o_state, 2);
        check_eq("pause_phase", cyc - t_tick, 20);
        sw1 = 1'b0;
        clear_ticks();
        step(150);
        check_eq("pause_no_ticks", tick_cnt, 0);
        check_eq("pause_hold_state", o_state, 2);
        sw1 = 1'b1;
        step(6);
        check_eq("resume_state", o_state, 1);
        r_cyc = cyc;
        sw1 = 1'b0;
        clear_ticks();
        for (int i = 0; i < 60 && first_tick < 0; i++) step(1);
        check_eq("resume_tick", first_tick - r_cyc, 30);

        // Lap: display hold while the count continues.
        t_tick = cyc;
        sw2 = 1'b1;
        step(6);
        check_eq("lap_state", o_state, 3);
        check_eq("lap_hold", o_hold, 1);
        sw2 = 1'b0;
        clear_ticks();
        step(94);
        check_eq("lap_tick_count", tick_cnt, 2);
        check_eq("lap_first_tick", first_tick - t_tick, 50);
        sw2 = 1'b1;
        step(6);
        check_eq("unlap_state", o_state, 1);
        check_eq("unlap_hold", o_hold, 0);
        sw2 = 1'b0;
        step(5);

        // PAUSE + LAP clears.
        sw1 = 1'b1;
        step(6);
        check_eq("pause2_state", o_state, 2);
        sw1 = 1'b0;
        step(5);
        sw2 = 1'b1;
        step(6);
        check_eq("pclear_state", o_state, 0);
        check_eq("pclear_clear", o_clear, 1);
        sw2 = 1'b0;
        step(5);

        // Both buttons together in RUN.
        sw1 = 1'b1;
        step(6);
        check_eq("run2_state", o_state, 1);
        sw1 = 1'b0;
        step(5);
        sw1 = 1'b1;
        sw2 = 1'b1;
        step(6);
        check_eq("both_state", o_state, 0);
        sw1 = 1'b0;
        sw2 = 1'b0;
        step(5);

        // Asynchronous reset while a tick pulse is high.
        sw1 = 1'b1;
        step(6);
        check_eq("run3_state", o_state, 1);
        sw1 = 1'b0;
        for (int i = 0; i < 60 && !o_tick; i++) step(1);
        check_eq("tick_before_rst", o_tick, 1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_tick", o_tick, 0);
        check_eq("async_rst_state", o_state, 0);
        check_eq("async_rst_clear", o_clear, 1);

        // Button held through reset release yields one press.
        sw1 = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(5);
        check_eq("held_edge5", o_state, 0);
        step(1);
        check_eq("held_edge6", o_state, 1);
        sw1 = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
